// File: rtl/audio_path_ctrl_if.sv
// ----------------------------------------------------------------------------
// audio_path_ctrl_if
// Purpose : Sample bus between the dry/wet effect-chain outputs, the source
//           selector and the codec serializer.
// Signals : dry_*_in / wet_*_in    24-bit source samples
//           dry_sp_* / wet_sp_*    source sample-valid strobes
//           data_*_out             selected 24-bit output samples
//           sp_*_out               one-cycle output sample strobes
// Modports: master - sample source / serializer side (drives inputs)
//           slave  - the path controller (drives outputs)
// ----------------------------------------------------------------------------
interface audio_path_ctrl_if;
    logic [23:0] dry_left_in;
    logic [23:0] dry_right_in;
    logic        dry_sp_left;
    logic        dry_sp_right;
    logic [23:0] wet_left_in;
    logic [23:0] wet_right_in;
    logic        wet_sp_left;
    logic        wet_sp_right;
    logic [23:0] data_left_out;
    logic [23:0] data_right_out;
    logic        sp_left_out;
    logic        sp_right_out;

    modport master (
        output dry_left_in, dry_right_in, dry_sp_left, dry_sp_right,
        output wet_left_in, wet_right_in, wet_sp_left, wet_sp_right,
        input  data_left_out, data_right_out, sp_left_out, sp_right_out
    );

    modport slave (
        input  dry_left_in, dry_right_in, dry_sp_left, dry_sp_right,
        input  wet_left_in, wet_right_in, wet_sp_left, wet_sp_right,
        output data_left_out, data_right_out, sp_left_out, sp_right_out
    );
endinterface

// File: rtl/audio_path_ctrl.sv
// ----------------------------------------------------------------------------
// audio_path_ctrl
// Purpose : Selects dry (passthrough) or wet (effect) audio for the output
//           stage, runs the 256-cycle sample frame and debounces the user
//           button. Each accepted press toggles the source through a
//           click-free MUTE -> SWAP -> HOLD sequence.
// Ports   : i_mclk   12.288 MHz clock
//           i_reset  synchronous active-high reset
//           i_btn    raw asynchronous push button
//           bus      sample bus (slave modport): inputs, strobes, outputs
//           o_mode   0 = dry, 1 = wet
//           o_muted  high whenever the sequencer is not in RUN
// ----------------------------------------------------------------------------
module audio_path_ctrl #(
    parameter int          DB_W            = 17,
    parameter int          DEBOUNCE_CYCLES = 122880,
    parameter int          MUTE_FRAMES     = 8,
    parameter logic [7:0]  LEFT_SLOT       = 8'hFF,
    parameter logic [7:0]  RIGHT_SLOT      = 8'h7F
) (
    input  logic              i_mclk,
    input  logic              i_reset,
    input  logic              i_btn,
    audio_path_ctrl_if.slave  bus,
    output logic              o_mode,
    output logic              o_muted
);

    localparam int              FRM_W    = (MUTE_FRAMES > 1) ? $clog2(MUTE_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(MUTE_FRAMES - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MUTE = 2'd1,
        ST_SWAP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Frame and capture registers
    logic [7:0]       r_cnt256;
    logic [23:0]      r_dry_left;
    logic [23:0]      r_dry_right;
    logic [23:0]      r_wet_left;
    logic [23:0]      r_wet_right;
    logic [23:0]      r_data_left;
    logic [23:0]      r_data_right;
    logic             r_sp_left;
    logic             r_sp_right;

    // Debounce registers
    logic             r_btn_meta;
    logic             r_btn_sync;
    logic             r_btn_stable;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_req;

    // Sequencer registers
    state_t           r_state;
    logic [FRM_W-1:0] r_frm_cnt;
    logic             r_mode;
    logic             r_muted;

    // Combinational nets
    logic             w_left_slot;
    logic             w_right_slot;
    logic             w_frm_last;
    logic             w_db_diff;
    logic             w_db_accept;
    state_t           w_state_nxt;
    logic             w_frm_clr;
    logic             w_frm_inc;
    logic             w_mode_tgl;
    logic [23:0]      w_left_sel;
    logic [23:0]      w_right_sel;

    assign w_left_slot  = (r_cnt256 == LEFT_SLOT);
    assign w_right_slot = (r_cnt256 == RIGHT_SLOT);
    assign w_frm_last   = (r_frm_cnt == FRM_LAST);
    assign w_db_diff    = (r_btn_sync != r_btn_stable);
    assign w_db_accept  = w_db_diff && (r_db_cnt == DB_LAST);

    // Free-running frame counter, wraps 8'hFF -> 8'h00
    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            r_cnt256 <= 8'd0;
        end else begin
            r_cnt256 <= r_cnt256 + 8'd1;
        end
    end

    // Unconditional capture of each source on its own strobe
    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            r_dry_left  <= 24'h000000;
            r_dry_right <= 24'h000000;
            r_wet_left  <= 24'h000000;
            r_wet_right <= 24'h000000;
        end else begin
            if (bus.dry_sp_left)  r_dry_left  <= bus.dry_left_in;
            if (bus.dry_sp_right) r_dry_right <= bus.dry_right_in;
            if (bus.wet_sp_left)  r_wet_left  <= bus.wet_left_in;
            if (bus.wet_sp_right) r_wet_right <= bus.wet_right_in;
        end
    end

    // Output source select: silence while muted, else wet or dry by mode
    always_comb begin
        w_left_sel  = 24'h000000;
        w_right_sel = 24'h000000;
        if (r_muted) begin
            w_left_sel  = 24'h000000;
            w_right_sel = 24'h000000;
        end else if (r_mode) begin
            w_left_sel  = r_wet_left;
            w_right_sel = r_wet_right;
        end else begin
            w_left_sel  = r_dry_left;
            w_right_sel = r_dry_right;
        end
    end

    // Output slot registers; the strobe lands in the cycle after the slot
    // together with the data, and a capture in the slot cycle itself is only
    // seen in the following frame.
    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            r_data_left  <= 24'h000000;
            r_data_right <= 24'h000000;
            r_sp_left    <= 1'b0;
            r_sp_right   <= 1'b0;
        end else begin
            r_sp_left  <= w_left_slot;
            r_sp_right <= w_right_slot;
            if (w_left_slot)  r_data_left  <= w_left_sel;
            if (w_right_slot) r_data_right <= w_right_sel;
        end
    end

    // Button synchronizer, debounce counter and press request pulse
    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            r_btn_meta   <= 1'b0;
            r_btn_sync   <= 1'b0;
            r_btn_stable <= 1'b0;
            r_db_cnt     <= {DB_W{1'b0}};
            r_req        <= 1'b0;
        end else begin
            r_btn_meta <= i_btn;
            r_btn_sync <= r_btn_meta;
            if (w_db_accept) begin
                r_btn_stable <= r_btn_sync;
                r_db_cnt     <= {DB_W{1'b0}};
            end else if (w_db_diff) begin
                r_db_cnt     <= r_db_cnt + {{(DB_W-1){1'b0}}, 1'b1};
            end else begin
                r_db_cnt     <= {DB_W{1'b0}};
            end
            // Only a newly accepted high level is a press
            r_req <= w_db_accept & r_btn_sync;
        end
    end

    // Sequencer state register
    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next-state logic; requests outside RUN are dropped
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (r_req) w_state_nxt = ST_MUTE;
                else       w_state_nxt = ST_RUN;
            end
            ST_MUTE: begin
                if (w_left_slot && w_frm_last) w_state_nxt = ST_SWAP;
                else                           w_state_nxt = ST_MUTE;
            end
            ST_SWAP: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_left_slot && w_frm_last) w_state_nxt = ST_RUN;
                else                           w_state_nxt = ST_HOLD;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Sequencer outputs: frame-count control and the mode toggle
    always_comb begin
        w_frm_clr  = 1'b0;
        w_frm_inc  = 1'b0;
        w_mode_tgl = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_frm_clr = r_req;
            end
            ST_MUTE, ST_HOLD: begin
                w_frm_inc = w_left_slot;
            end
            ST_SWAP: begin
                w_frm_clr  = 1'b1;
                w_mode_tgl = 1'b1;
            end
            default: begin
                w_frm_clr  = 1'b0;
                w_frm_inc  = 1'b0;
                w_mode_tgl = 1'b0;
            end
        endcase
    end

    // Frame counter, mode and muted flag; muted follows the next state so
    // it is a plain register that equals (state != RUN) every cycle.
    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            r_frm_cnt <= {FRM_W{1'b0}};
            r_mode    <= 1'b0;
            r_muted   <= 1'b0;
        end else begin
            if (w_frm_clr) begin
                r_frm_cnt <= {FRM_W{1'b0}};
            end else if (w_frm_inc) begin
                r_frm_cnt <= r_frm_cnt + {{(FRM_W-1){1'b0}}, 1'b1};
            end
            if (w_mode_tgl) r_mode <= ~r_mode;
            r_muted <= (w_state_nxt != ST_RUN);
        end
    end

    assign bus.data_left_out  = r_data_left;
    assign bus.data_right_out = r_data_right;
    assign bus.sp_left_out    = r_sp_left;
    assign bus.sp_right_out   = r_sp_right;
    assign o_mode             = r_mode;
    assign o_muted            = r_muted;

endmodule
